// File: rtl/part_sweep_ctl.sv
// Sweep sequencer for the partition lookup stage: walks (a,b,c) in odometer order and captures xPart/yPart bitmaps.
// Optional build macro PART_SWEEP_PARITY_EN adds the map_parity output.
module part_sweep_ctl #(
    parameter int DIM        = 3,
    parameter int IDX_W      = 2,
    parameter int SETTLE_CYC = 2,
    localparam int NPTS      = DIM * DIM * DIM,
    localparam int CNT_W     = $clog2(NPTS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  sel_a,
    output logic [IDX_W-1:0]  sel_b,
    output logic [IDX_W-1:0]  sel_c,
    input  logic              x_in,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic [NPTS-1:0]   x_map,
    output logic [NPTS-1:0]   y_map,
    output logic [CNT_W-1:0]  mismatch_cnt
`ifdef PART_SWEEP_PARITY_EN
    ,
    output logic [1:0]        map_parity
`endif
);

    localparam int K_W   = $clog2(NPTS);
    localparam int SCT_W = 4;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DIM - 1);
    localparam logic [SCT_W-1:0] SETTLE_LAST = SCT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_a_q, sel_a_d;
    logic [IDX_W-1:0]   sel_b_q, sel_b_d;
    logic [IDX_W-1:0]   sel_c_q, sel_c_d;
    logic [SCT_W-1:0]   settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NPTS-1:0]    x_map_q, x_map_d;
    logic [NPTS-1:0]    y_map_q, y_map_d;
    logic [CNT_W-1:0]   mism_q, mism_d;
    logic [1:0]         par_q, par_d;

    logic [K_W-1:0]     pt_idx;
    logic               last_pt;

    // Bit position of the current point in the response maps (a is the most significant digit).
    always_comb begin
        pt_idx  = K_W'(int'(sel_a_q) * DIM * DIM + int'(sel_b_q) * DIM + int'(sel_c_q));
        last_pt = (sel_a_q == IDX_LAST) && (sel_b_q == IDX_LAST) && (sel_c_q == IDX_LAST);
    end

    always_comb begin
        state_d  = state_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        sel_c_d  = sel_c_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x_map_d  = x_map_q;
        y_map_d  = y_map_q;
        mism_d   = mism_q;
        par_d    = par_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = SETTLE;
                    busy_d   = 1'b1;
                    sel_a_d  = '0;
                    sel_b_d  = '0;
                    sel_c_d  = '0;
                    settle_d = '0;
                    x_map_d  = '0;
                    y_map_d  = '0;
                    mism_d   = '0;
                    par_d    = '0;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    sel_a_d  = '0;
                    sel_b_d  = '0;
                    sel_c_d  = '0;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + SCT_W'(1);
                end
            end

            SAMPLE: begin
                if (abort) begin
                    // Aborting here deliberately skips the capture of the current point.
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    sel_a_d  = '0;
                    sel_b_d  = '0;
                    sel_c_d  = '0;
                    settle_d = '0;
                end else begin
                    x_map_d[pt_idx] = x_in;
                    y_map_d[pt_idx] = y_in;
                    if (x_in != y_in) begin
                        mism_d = mism_q + CNT_W'(1);
                    end
                    // Each bit is written once per sweep from a cleared map, so folding in the new bit keeps parity exact.
                    par_d = par_q ^ {x_in, y_in};
                    settle_d = '0;
                    if (last_pt) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sel_a_d = '0;
                        sel_b_d = '0;
                        sel_c_d = '0;
                    end else begin
                        state_d = SETTLE;
                        if (sel_c_q == IDX_LAST) begin
                            sel_c_d = '0;
                            if (sel_b_q == IDX_LAST) begin
                                sel_b_d = '0;
                                sel_a_d = sel_a_q + IDX_W'(1);
                            end else begin
                                sel_b_d = sel_b_q + IDX_W'(1);
                            end
                        end else begin
                            sel_c_d = sel_c_q + IDX_W'(1);
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                sel_a_d  = '0;
                sel_b_d  = '0;
                sel_c_d  = '0;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            sel_c_q  <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_map_q  <= '0;
            y_map_q  <= '0;
            mism_q   <= '0;
            par_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            sel_c_q  <= sel_c_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            x_map_q  <= x_map_d;
            y_map_q  <= y_map_d;
            mism_q   <= mism_d;
            par_q    <= par_d;
        end
    end

    assign sel_a        = sel_a_q;
    assign sel_b        = sel_b_q;
    assign sel_c        = sel_c_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign x_map        = x_map_q;
    assign y_map        = y_map_q;
    assign mismatch_cnt = mism_q;

`ifdef PART_SWEEP_PARITY_EN
    assign map_parity = par_q;
`else
    logic par_unused;
    assign par_unused = ^par_q;
`endif

endmodule

// File: doc/part_sweep_ctl.md
Name: part_sweep_ctl

Overview:
Sequencer that drives the three ternary select inputs (a, b, c) of the event-control partition lookup stage and captures its xPart/yPart responses.
- Walks every index combination in odometer order; each point is held stable for a programmable settle time before sampling.
- Builds two response bitmaps and a mismatch count.
- Sits directly upstream of the lookup stage (feeds its selects) and directly consumes its outputs; used for table characterisation and self-check.

Parameters:
- DIM, 3, values per select axis (2..4); points per sweep NPTS = DIM**3.
- IDX_W, 2, width of each select output; must satisfy 2**IDX_W >= DIM.
- SETTLE_CYC, 2, cycles the index is held before sampling (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- abort  in  1  terminate the sweep; honoured in any state.
- sel_a  out  IDX_W  select a (most significant digit).
- sel_b  out  IDX_W  select b.
- sel_c  out  IDX_W  select c (least significant digit).
- x_in  in  1  xPart response from the lookup stage.
- y_in  in  1  yPart response from the lookup stage.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- x_map  out  NPTS  captured xPart; bit k = a*DIM*DIM + b*DIM + c.
- y_map  out  NPTS  captured yPart, same bit ordering.
- mismatch_cnt  out  $clog2(NPTS+1)  count of points where x_in != y_in.

Behaviour:
- Reset (async, rst_n=0): state IDLE; sel_a/b/c=0, busy=0, done=0, x_map=0, y_map=0, mismatch_cnt=0, settle counter=0.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1 and abort=0 at an edge:
  - go to SETTLE, busy=1, sel=(0,0,0);
  - clear x_map, y_map, mismatch_cnt and the settle counter.
- SETTLE: counter increments each cycle; when counter==SETTLE_CYC-1, go to SAMPLE. Selects stay constant.
- SAMPLE (one cycle), at the edge leaving SAMPLE:
  - x_map[k]<=x_in, y_map[k]<=y_in;
  - mismatch_cnt increments if x_in!=y_in;
  - if index is (DIM-1,DIM-1,DIM-1), go to DONE;
  - otherwise advance the index and go to SETTLE with counter=0.
- Index advance is an odometer: c+1; when c wraps from DIM-1 to 0, b+1; when b wraps, a+1. Select values never exceed DIM-1.
- Per point: exactly SETTLE_CYC+1 cycles. Sweep length: NPTS*(SETTLE_CYC+1) busy cycles (81 at defaults).
- DONE (one cycle): done=1, busy=0, sel returns to 0. Maps and count hold. Next state IDLE.
- Results remain valid until the next accepted start or reset.
- start while busy or in DONE: ignored, with no queuing.
- abort=1 in SETTLE/SAMPLE/DONE: next state IDLE, busy=0, sel=0, done not pulsed.
  - Partial maps and count hold; SAMPLE does not capture in the abort cycle.
- start and abort together in IDLE: abort wins, and the sweep does not start.
- Reset mid-sweep: immediate return to reset values.

Optional Feature:
PART_SWEEP_PARITY_EN
- Defined: adds output map_parity (2 bits). [1] = XOR of all x_map bits, [0] = XOR of all y_map bits.
  - Parity is updated incrementally at each SAMPLE and cleared on accepted start.
  - It is valid while done=1 and thereafter.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Reset, then start pulse with SETTLE_CYC=2 and x_in=y_in=0 → busy high for 81 cycles, then done for 1 cycle; x_map=y_map=0 and mismatch_cnt=0.
- Model returns x_in = table[a][b][c] with x_map 27'h5A5A5A5 and y_in = ~x_in → captured x_map=27'h5A5A5A5, y_map=27'h2A5A5A5A & 27'h7FFFFFF, mismatch_cnt=27.
- Monitor selects across the sweep → sequence (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(2,2,2); each value held 3 cycles; never 3.
- abort asserted on the 10th point → busy drops next cycle, no done, sel=0; only bits 0..8 are updated.
- start reasserted mid-sweep, and start+abort together in IDLE → the sweep is unaffected by the mid-sweep start, and no sweep starts from the combined request.
- With PART_SWEEP_PARITY_EN defined and the second scenario's stimulus → map_parity = {^27'h5A5A5A5, ^y_map} at done.
